// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the MMIO I/O controller: register offsets,
// status bit positions and TX state encodings.
package mmio_io_ctrl_pkg;

    localparam logic [7:0] IO_STATUS  = 8'h00;
    localparam logic [7:0] IO_RX_DATA = 8'h04;
    localparam logic [7:0] IO_TX_DATA = 8'h08;
    localparam logic [7:0] IO_CYCLE   = 8'h10;
    localparam logic [7:0] IO_INSTRET = 8'h14;
    localparam logic [7:0] IO_CNT_RST = 8'h18;

    localparam int STAT_TX_IDLE   = 0;
    localparam int STAT_RX_NEMPTY = 1;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// Bus between the load/store stage, the UART and the MMIO I/O controller.
// The master side is the pipeline plus UART; the slave side is the controller.
interface mmio_io_ctrl_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        io_recv;
    logic [3:0]  io_trans;
    logic        inst_retire;
    logic [31:0] rdata;
    logic        stall;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    modport master (
        output addr, wdata, io_recv, io_trans, inst_retire,
        output uart_tx_ready, uart_rx_data, uart_rx_valid,
        input  rdata, stall, uart_tx_data, uart_tx_valid, uart_rx_ready
    );

    modport slave (
        input  addr, wdata, io_recv, io_trans, inst_retire,
        input  uart_tx_ready, uart_rx_data, uart_rx_valid,
        output rdata, stall, uart_tx_data, uart_tx_valid, uart_rx_ready
    );

endinterface

// File: rtl/mmio_io_ctrl_io_rx_fifo.sv
// Synchronous byte FIFO for the UART receive path. DEPTH must be a power of
// two so the pointers wrap by plain overflow.
module io_rx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only; emptiness is tracked by the count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO I/O controller: UART TX sequencing with pipeline stall, buffered RX,
// cycle/instret counters and registered read-back to writeback.
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic          clk,
    input  logic          rst,
    mmio_io_ctrl_if.slave io
);

    logic [7:0]           off;
    logic                 tx_wr;
    logic                 cnt_clr;
    logic                 rx_rd;
    tx_state_e            state_q, state_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [7:0]           rx_head;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 unused_bits;

    assign off         = io.addr[7:0];
    assign tx_wr       = io.io_trans[0] && (off == IO_TX_DATA);
    assign cnt_clr     = (|io.io_trans) && (off == IO_CNT_RST);
    assign rx_rd       = io.io_recv && (off == IO_RX_DATA);
    assign unused_bits = ^{io.addr[31:8], io.wdata[31:8]};

    io_rx_fifo #(
        .DEPTH  (RX_FIFO_DEPTH),
        .DATA_W (8)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (io.uart_rx_valid),
        .pop_i   (rx_rd),
        .din_i   (io.uart_rx_data),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign io.uart_rx_ready = !rx_full;
    assign io.uart_tx_valid = (state_q == TX_SEND);
    assign io.uart_tx_data  = tx_data_q;
    assign io.rdata         = rdata_q;

    // A TX store arriving mid-send is held off until the FSM is idle again.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        io.stall  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (tx_wr) begin
                    state_d   = TX_SEND;
                    tx_data_d = io.wdata[7:0];
                end
            end
            TX_SEND: begin
                if (tx_wr) io.stall = 1'b1;
                if (io.uart_tx_ready) state_d = TX_IDLE;
            end
        endcase
    end

    always_comb begin
        cycle_d   = cnt_clr ? '0 : cycle_q + 1'b1;
        instret_d = cnt_clr ? '0 : instret_q + CNT_WIDTH'(io.inst_retire);
    end

    always_comb begin
        rdata_d = '0;
        case (off)
            IO_STATUS: begin
                rdata_d[STAT_TX_IDLE]   = (state_q == TX_IDLE);
                rdata_d[STAT_RX_NEMPTY] = !rx_empty;
            end
            IO_RX_DATA: if (!rx_empty) rdata_d = {24'b0, rx_head};
            IO_CYCLE:   rdata_d = 32'(cycle_q);
            IO_INSTRET: rdata_d = 32'(instret_q);
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            tx_data_q <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            if (io.io_recv) rdata_q <= rdata_d;
        end
    end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O controller behind the memory-control stage. It turns the io_recv/io_trans strobes from the load/store path into UART transactions, a buffered RX path and performance counters.
- It sequences the UART ready/valid handshakes, buffers received bytes in a small FIFO and returns registered read data to the writeback mux.
- It stalls the pipeline when a TX store arrives while the transmitter is busy.

Parameters:
RX_FIFO_DEPTH, 4, RX byte FIFO entries; power of two, minimum 2.
CNT_WIDTH, 32, width of the cycle and instret counters.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
addr  input  32  memory address of the current load/store
wdata  input  32  store data, already lane-shifted
io_recv  input  1  load to I/O space (addr[31:28]==4'b1000)
io_trans  input  4  store byte mask to I/O space; nonzero means store
inst_retire  input  1  one instruction retired this cycle
rdata  output  32  registered I/O read data
stall  output  1  freeze pipeline this cycle
uart_tx_data  output  8  byte to UART transmitter
uart_tx_valid  output  1  TX byte valid
uart_tx_ready  input  1  UART transmitter accepts byte
uart_rx_data  input  8  byte from UART receiver
uart_rx_valid  input  1  RX byte valid
uart_rx_ready  output  1  controller accepts RX byte

Behaviour:
Address map (decode addr[7:0] only; addr[31:28]==8 is already qualified by the strobes):
- 0x00: status (read). Bit0 = TX idle. Bit1 = RX FIFO non-empty. Other bits are 0.
- 0x04: RX data (read). Bits [7:0] = FIFO head. A read pops the head.
- 0x08: TX data (write). Takes wdata[7:0]; io_trans[0] must be set.
- 0x10: cycle counter (read).
- 0x14: instret counter (read).
- 0x18: counter reset (write). Any nonzero io_trans clears both counters.
- Unmapped reads return 0. Unmapped writes are ignored.

Read path:
- rdata is registered: the value for an io_recv in cycle N appears in cycle N+1.
- rdata holds its value when io_recv is low.
- An RX-data read with the FIFO empty returns 0 and does not pop.

TX FSM (states TX_IDLE and TX_SEND):
- TX_IDLE: on a store to 0x08, latch wdata[7:0] and go to TX_SEND next cycle.
- TX_SEND: uart_tx_valid=1 and uart_tx_data is held stable. Return to TX_IDLE in the cycle after uart_tx_valid && uart_tx_ready.
- A store to 0x08 while in TX_SEND asserts stall combinationally. Stall stays high until the FSM is in TX_IDLE, and the store is accepted in that cycle.
- stall is never asserted for any other access.

RX FIFO:
- uart_rx_ready = !full. Push when uart_rx_valid && uart_rx_ready.
- Pop on a read of 0x04 when the FIFO is not empty.
- Simultaneous push and pop is legal; the count is unchanged.
- Pointers wrap modulo RX_FIFO_DEPTH. Count width is log2(DEPTH)+1.

Counters:
- cycle increments every cycle. instret increments when inst_retire is high.
- Both wrap modulo 2^CNT_WIDTH.
- A clear store wins over increment: the counter reads 0 in the next cycle.
- Reads above 32 bits return the low 32 bits.

Reset (synchronous):
- rdata=0, stall=0, uart_tx_valid=0, uart_tx_data=0, uart_rx_ready=1.
- FIFO is emptied, both counters are 0, and the FSM goes to TX_IDLE.
- A reset during TX_SEND drops valid in the next cycle and the byte is lost.

Decomposition:
- Shared package holds the I/O offset constants (IO_STATUS, IO_RX_DATA, IO_TX_DATA, IO_CYCLE, IO_INSTRET, IO_CNT_RST), the status bit indices and the TX state encodings.
- One sub-module: io_rx_fifo (parameterised synchronous FIFO with push, pop, full, empty and head outputs).

Test Plan:
1. Reset, then read 0x00 → rdata=32'h1 in the next cycle; uart_rx_ready=1; stall=0.
2. Store 0x41 to 0x08 with uart_tx_ready low for 3 cycles, then high → uart_tx_valid high for 4 cycles with data 0x41; status bit0 returns to 1 afterwards.
3. A second TX store while in TX_SEND → stall high until TX_IDLE; the second byte is sent after the first.
4. Push 0x11, 0x22, 0x33, 0x44, 0x55 with DEPTH=4 → uart_rx_ready drops after 4 pushes. Four reads of 0x04 return 0x11–0x44 in order. A fifth read returns 0 and status bit1=0.
5. Run 100 cycles with inst_retire every other cycle, then read 0x10 and 0x14 → values consistent with 100 and 50 (read latency accounted for). Store to 0x18 → both read 0 in the next cycle, then resume counting.
6. Assert rst while in TX_SEND with a full FIFO → in the next cycle valid=0, FIFO empty, status=32'h1.
